// File: rtl/hazard_pkg.sv
// Shared forwarding-select encodings for the hazard unit and its consumers.
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding compare: execute-stage mux select and decode-stage branch forward.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0] src_e,
  input  logic [RW-1:0] src_d,
  input  logic          regwrite_m,
  input  logic [RW-1:0] writereg_m,
  input  logic          regwrite_w,
  input  logic [RW-1:0] writereg_w,
  output fwd_sel_t      fwd_e,
  output logic          fwd_d
);

  // Register 0 is hardwired zero and never forwarded; the memory stage is younger, so it wins.
  always_comb begin
    fwd_e = FWD_RF;
    if (src_e != '0 && regwrite_m && src_e == writereg_m)
      fwd_e = FWD_MEM;
    else if (src_e != '0 && regwrite_w && src_e == writereg_w)
      fwd_e = FWD_WB;
  end

  assign fwd_d = (src_d != '0) && regwrite_m && (src_d == writereg_m);

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: forwarding selects, load-use/branch/long-latency stalls, busy scoreboard.
// Optional HAZARD_STALL_CNT_EN adds a saturating count of decode-stall cycles on stall_cnt.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG = 32,
  parameter int RW   = $clog2(NREG),
  parameter int NSRC = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NSRC*RW-1:0] src_d,
  input  logic [NSRC*RW-1:0] src_e,
  input  logic               branch_d,
  input  logic               regwrite_e,
  input  logic               memtoreg_e,
  input  logic [RW-1:0]      writereg_e,
  input  logic               regwrite_m,
  input  logic               memtoreg_m,
  input  logic [RW-1:0]      writereg_m,
  input  logic               regwrite_w,
  input  logic [RW-1:0]      writereg_w,
  input  logic               lat_issue_e,
  input  logic [RW-1:0]      lat_dest_e,
  input  logic               lat_done,
  input  logic [RW-1:0]      lat_done_dest,
  output logic [2*NSRC-1:0]  forward_e,
  output logic [NSRC-1:0]    forward_d,
  output logic               stall_f,
  output logic               stall_d,
  output logic               flush_e,
`ifdef HAZARD_STALL_CNT_EN
  output logic [31:0]        stall_cnt,
`endif
  output logic [NREG-1:0]    sb_busy
);

  for (genvar i = 0; i < NSRC; i++) begin : g_fwd
    hazard_fwd_sel #(.RW(RW)) u_fwd_sel (
      .src_e      (src_e[i*RW +: RW]),
      .src_d      (src_d[i*RW +: RW]),
      .regwrite_m (regwrite_m),
      .writereg_m (writereg_m),
      .regwrite_w (regwrite_w),
      .writereg_w (writereg_w),
      .fwd_e      (forward_e[2*i +: 2]),
      .fwd_d      (forward_d[i])
    );
  end

  logic          lw_stall;
  logic          br_stall;
  logic          sb_stall;
  logic          stall;
  logic [RW-1:0] src;

  // The scoreboard term is masked while reset is high so stale busy bits never stall.
  always_comb begin
    lw_stall = 1'b0;
    br_stall = 1'b0;
    sb_stall = 1'b0;
    src      = '0;
    for (int i = 0; i < NSRC; i++) begin
      src = src_d[i*RW +: RW];
      if (memtoreg_e && writereg_e != '0 && writereg_e == src)
        lw_stall = 1'b1;
      if (src != '0) begin
        if (branch_d && ((regwrite_e && writereg_e == src) ||
                         (memtoreg_m && writereg_m == src)))
          br_stall = 1'b1;
        if (sb_busy[src] && !reset)
          sb_stall = 1'b1;
      end
    end
  end

  assign stall   = lw_stall | br_stall | sb_stall;
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;

  // Set is written after clear so a new writer to the same register keeps the bit busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_busy <= '0;
    end else begin
      if (lat_done)
        sb_busy[lat_done_dest] <= 1'b0;
      if (lat_issue_e && lat_dest_e != '0)
        sb_busy[lat_dest_e] <= 1'b1;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall_d && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vector table for combinational paths, sequences for scoreboard state.
module tb_hazard_scoreboard;

  localparam int NREG = 32;
  localparam int RW   = 5;
  localparam int NSRC = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NSRC*RW-1:0] src_d, src_e;
  logic               branch_d, regwrite_e, memtoreg_e;
  logic [RW-1:0]      writereg_e;
  logic               regwrite_m, memtoreg_m;
  logic [RW-1:0]      writereg_m;
  logic               regwrite_w;
  logic [RW-1:0]      writereg_w;
  logic               lat_issue_e, lat_done;
  logic [RW-1:0]      lat_dest_e, lat_done_dest;
  logic [2*NSRC-1:0]  forward_e;
  logic [NSRC-1:0]    forward_d;
  logic               stall_f, stall_d, flush_e;
  logic [NREG-1:0]    sb_busy;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0]        stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  hazard_scoreboard #(.NREG(NREG), .RW(RW), .NSRC(NSRC)) dut (
    .clk           (clk),
    .reset         (reset),
    .src_d         (src_d),
    .src_e         (src_e),
    .branch_d      (branch_d),
    .regwrite_e    (regwrite_e),
    .memtoreg_e    (memtoreg_e),
    .writereg_e    (writereg_e),
    .regwrite_m    (regwrite_m),
    .memtoreg_m    (memtoreg_m),
    .writereg_m    (writereg_m),
    .regwrite_w    (regwrite_w),
    .writereg_w    (writereg_w),
    .lat_issue_e   (lat_issue_e),
    .lat_dest_e    (lat_dest_e),
    .lat_done      (lat_done),
    .lat_done_dest (lat_done_dest),
    .forward_e     (forward_e),
    .forward_d     (forward_d),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .flush_e       (flush_e),
`ifdef HAZARD_STALL_CNT_EN
    .stall_cnt     (stall_cnt),
`endif
    .sb_busy       (sb_busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [9:0]   src_d;
    logic [9:0]   src_e;
    logic         branch_d;
    logic         regwrite_e;
    logic         memtoreg_e;
    logic [4:0]   writereg_e;
    logic         regwrite_m;
    logic         memtoreg_m;
    logic [4:0]   writereg_m;
    logic         regwrite_w;
    logic [4:0]   writereg_w;
    logic [3:0]   exp_fe;
    logic [1:0]   exp_fd;
    logic         exp_stall;
  } vec_t;

  vec_t vecs[13];

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src_d = '0; src_e = '0; branch_d = 1'b0;
    regwrite_e = 1'b0; memtoreg_e = 1'b0; writereg_e = '0;
    regwrite_m = 1'b0; memtoreg_m = 1'b0; writereg_m = '0;
    regwrite_w = 1'b0; writereg_w = '0;
    lat_issue_e = 1'b0; lat_dest_e = '0; lat_done = 1'b0; lat_done_dest = '0;
  endtask

  task automatic apply_vec(input vec_t v);
    src_d = v.src_d; src_e = v.src_e; branch_d = v.branch_d;
    regwrite_e = v.regwrite_e; memtoreg_e = v.memtoreg_e; writereg_e = v.writereg_e;
    regwrite_m = v.regwrite_m; memtoreg_m = v.memtoreg_m; writereg_m = v.writereg_m;
    regwrite_w = v.regwrite_w; writereg_w = v.writereg_w;
  endtask

  // Scoreboard
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_stall(input string name, input logic exp);
    check({name, ".stall_f"}, 64'(stall_f), 64'(exp));
    check({name, ".stall_d"}, 64'(stall_d), 64'(exp));
    check({name, ".flush_e"}, 64'(flush_e), 64'(exp));
  endtask

  initial begin
    //                name            src_d           src_e           br  re  me  we     rm  mm  wm     rw  ww     fe       fd     st
    vecs[0]  = '{"fwd_mem_wins",  {5'd0, 5'd0},  {5'd0, 5'd5},  0,  0,  0,  5'd0,  1,  0,  5'd5,  1,  5'd5,  4'b0010, 2'b00, 0};
    vecs[1]  = '{"fwd_r0",        {5'd0, 5'd0},  {5'd0, 5'd0},  0,  0,  0,  5'd0,  1,  0,  5'd0,  1,  5'd0,  4'b0000, 2'b00, 0};
    vecs[2]  = '{"fwd_mix",       {5'd0, 5'd0},  {5'd7, 5'd3},  0,  0,  0,  5'd0,  1,  0,  5'd3,  1,  5'd7,  4'b0110, 2'b00, 0};
    vecs[3]  = '{"fwd_wb_only",   {5'd0, 5'd0},  {5'd0, 5'd3},  0,  0,  0,  5'd0,  0,  0,  5'd3,  1,  5'd3,  4'b0001, 2'b00, 0};
    vecs[4]  = '{"fwd_no_wen",    {5'd0, 5'd0},  {5'd3, 5'd3},  0,  0,  0,  5'd0,  0,  0,  5'd3,  0,  5'd3,  4'b0000, 2'b00, 0};
    vecs[5]  = '{"loaduse_hit",   {5'd8, 5'd0},  {5'd0, 5'd0},  0,  1,  1,  5'd8,  0,  0,  5'd0,  0,  5'd0,  4'b0000, 2'b00, 1};
    vecs[6]  = '{"loaduse_miss",  {5'd8, 5'd0},  {5'd0, 5'd0},  0,  1,  1,  5'd9,  0,  0,  5'd0,  0,  5'd0,  4'b0000, 2'b00, 0};
    vecs[7]  = '{"loaduse_r0",    {5'd0, 5'd0},  {5'd0, 5'd0},  0,  1,  1,  5'd0,  0,  0,  5'd0,  0,  5'd0,  4'b0000, 2'b00, 0};
    vecs[8]  = '{"branch_e",      {5'd0, 5'd4},  {5'd0, 5'd0},  1,  1,  0,  5'd4,  0,  0,  5'd0,  0,  5'd0,  4'b0000, 2'b00, 1};
    vecs[9]  = '{"branch_m_fwd",  {5'd0, 5'd4},  {5'd0, 5'd0},  1,  0,  0,  5'd0,  1,  0,  5'd4,  0,  5'd0,  4'b0000, 2'b01, 0};
    vecs[10] = '{"branch_m_load", {5'd0, 5'd4},  {5'd0, 5'd0},  1,  0,  0,  5'd0,  1,  1,  5'd4,  0,  5'd0,  4'b0000, 2'b01, 1};
    vecs[11] = '{"alu_no_branch", {5'd0, 5'd4},  {5'd0, 5'd0},  0,  1,  0,  5'd4,  0,  0,  5'd0,  0,  5'd0,  4'b0000, 2'b00, 0};
    vecs[12] = '{"fwd_d_both",    {5'd6, 5'd6},  {5'd0, 5'd0},  0,  0,  0,  5'd0,  1,  0,  5'd6,  0,  5'd0,  4'b0000, 2'b11, 0};

    clear_inputs();
    reset = 1'b1;
    repeat (2) tick();
    check("reset.sb_busy", 64'(sb_busy), 64'h0);
    check_stall("reset", 1'b0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      apply_vec(vecs[i]);
      #2;
      check({vecs[i].name, ".forward_e"}, 64'(forward_e), 64'(vecs[i].exp_fe));
      check({vecs[i].name, ".forward_d"}, 64'(forward_d), 64'(vecs[i].exp_fd));
      check_stall(vecs[i].name, vecs[i].exp_stall);
    end
    clear_inputs();
    tick();

    // Long-latency op to r12: stall until the cycle after lat_done
    lat_issue_e = 1'b1; lat_dest_e = 5'd12;
    tick();
    lat_issue_e = 1'b0; lat_dest_e = '0;
    src_d = {5'd0, 5'd12};
    #1;
    check("lat.busy12_set", 64'(sb_busy[12]), 64'h1);
    check_stall("lat.pending", 1'b1);
    tick();
    check_stall("lat.pending2", 1'b1);
    lat_done = 1'b1; lat_done_dest = 5'd12;
    #1;
    check_stall("lat.done_cycle", 1'b1);
    tick();
    lat_done = 1'b0; lat_done_dest = '0;
    #1;
    check_stall("lat.released", 1'b0);
    check("lat.busy12_clr", 64'(sb_busy[12]), 64'h0);
    src_d = '0;

    // Same-register set/clear collision, independent registers, r0, redundant done
    lat_issue_e = 1'b1; lat_dest_e = 5'd3;
    tick();
    check("coll.busy3_pre", 64'(sb_busy), 64'h0000_0008);
    lat_done = 1'b1; lat_done_dest = 5'd3;
    tick();
    check("coll.busy3_kept", 64'(sb_busy), 64'h0000_0008);
    lat_dest_e = 5'd5;
    src_d = {5'd5, 5'd0};
    #1;
    check_stall("coll.slot1_clear", 1'b0);
    tick();
    check("indep.busy5_set_3_clr", 64'(sb_busy), 64'h0000_0020);
    lat_done = 1'b0; lat_dest_e = 5'd0;
    #1;
    check_stall("sb.slot1_busy", 1'b1);
    tick();
    check("r0.never_busy", 64'(sb_busy), 64'h0000_0020);
    lat_issue_e = 1'b0; lat_done = 1'b1; lat_done_dest = 5'd9;
    tick();
    check("done_clear_bit", 64'(sb_busy), 64'h0000_0020);
    lat_done_dest = 5'd5; src_d = '0;
    tick();
    lat_done = 1'b0;
    check("busy5_cleared", 64'(sb_busy), 64'h0);

    // Reset overrides a simultaneous issue and masks stale busy bits
    lat_issue_e = 1'b1; lat_dest_e = 5'd4;
    tick();
    lat_dest_e = 5'd12;
    tick();
    check("rst.busy_pre", 64'(sb_busy), 64'h0000_1010);
    reset = 1'b1; lat_dest_e = 5'd7; src_d = {5'd0, 5'd4};
    #1;
    check_stall("rst.no_stale_stall", 1'b0);
    tick();
    reset = 1'b0; lat_issue_e = 1'b0; lat_dest_e = '0; src_d = '0;
    check("rst.busy_cleared", 64'(sb_busy), 64'h0);
`ifdef HAZARD_STALL_CNT_EN
    check("rst.stall_cnt", 64'(stall_cnt), 64'h0);
    memtoreg_e = 1'b1; regwrite_e = 1'b1; writereg_e = 5'd8; src_d = {5'd8, 5'd0};
    repeat (3) tick();
    clear_inputs();
    tick();
    check("stall_cnt.three", 64'(stall_cnt), 64'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning number of architectural registers (power of two, >= 2).
REQ-002 SHALL have parameter RW, default $clog2(NREG), meaning register-address width.
REQ-003 SHALL have parameter NSRC, default 2, meaning source operands per instruction.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-006 SHALL have port src_d  input  NSRC*RW  meaning decode-stage source addresses; slot i is bits [i*RW +: RW].
REQ-007 SHALL have port src_e  input  NSRC*RW  meaning execute-stage source addresses.
REQ-008 SHALL have port branch_d  input  1  meaning the decode instruction compares sources for a branch.
REQ-009 SHALL have ports regwrite_e, memtoreg_e  input  1 each, plus writereg_e  input  RW  meaning execute-stage write enable, load flag and destination.
REQ-010 SHALL have ports regwrite_m, memtoreg_m  input  1 each, plus writereg_m  input  RW  meaning the memory-stage equivalents.
REQ-011 SHALL have ports regwrite_w  input  1  and writereg_w  input  RW  meaning writeback-stage write enable and destination.
REQ-012 SHALL have ports lat_issue_e  input  1  and lat_dest_e  input  RW  meaning a long-latency (mult/div) op leaves execute and will write lat_dest_e later.
REQ-013 SHALL have ports lat_done  input  1  and lat_done_dest  input  RW  meaning a long-latency result is written to the register file this cycle.
REQ-014 SHALL have port forward_e  output  2*NSRC  meaning per-slot execute forwarding select.
REQ-015 SHALL have port forward_d  output  NSRC  meaning per-slot decode-stage (branch) forward from memory stage.
REQ-016 SHALL have ports stall_f, stall_d, flush_e  output  1 each  meaning fetch stall, decode stall, execute bubble insert.
REQ-017 SHALL have port sb_busy  output  NREG  meaning the registered scoreboard pending-write vector.

Function
REQ-018 SHALL drive forward_e slot i = 2'b10 if src_e[i]!=0 and src_e[i]==writereg_m and regwrite_m; else 2'b01 if src_e[i]!=0 and src_e[i]==writereg_w and regwrite_w; else 2'b00 (memory stage wins).
REQ-019 SHALL drive forward_d[i] = 1 iff src_d[i]!=0 and src_d[i]==writereg_m and regwrite_m.
REQ-020 SHALL raise load-use stall iff memtoreg_e and writereg_e!=0 and writereg_e equals any src_d slot.
REQ-021 SHALL raise branch stall iff branch_d and, for any nonzero src_d slot, (regwrite_e and writereg_e match) or (memtoreg_m and writereg_m match).
REQ-022 SHALL raise scoreboard stall iff any nonzero src_d slot has its sb_busy bit set, including the cycle lat_done clears it (released next cycle).
REQ-023 SHALL drive stall_f = stall_d = flush_e = OR of REQ-020..022, combinationally, zero-cycle latency.
REQ-024 SHALL set sb_busy[lat_dest_e] at the edge after lat_issue_e, and clear sb_busy[lat_done_dest] at the edge after lat_done.
REQ-025 SHALL, when set and clear target the same register in one cycle, leave the bit set (new writer wins); different registers update independently.
REQ-026 SHALL never set sb_busy[0]; issue or done to register 0 is ignored.
REQ-027 SHALL ignore lat_done to a register whose bit is already clear (no error, no state change).

Reset
REQ-028 SHALL clear sb_busy to all zeros on a clock edge with reset high, overriding simultaneous issue/done.
REQ-029 SHALL, during and after reset, produce combinational outputs from current inputs only (no stall from stale state).

Configuration
REQ-030 SHALL, with HAZARD_STALL_CNT_EN defined, add output stall_cnt (32 bits) counting cycles with stall_d high, saturating at 32'hFFFF_FFFF, cleared by reset.
REQ-031 SHALL, without HAZARD_STALL_CNT_EN, omit stall_cnt and its flops; all other behaviour identical.

Structure
REQ-032 SHALL take forwarding encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10 from shared package hazard_pkg.
REQ-033 SHALL implement per-slot compare/priority logic in sub-module hazard_fwd_sel, instantiated NSRC times.

Verification
REQ-034 SHALL cover: src_e slot0=5, writereg_m=5 regwrite_m=1, writereg_w=5 regwrite_w=1 -> forward_e[1:0]=2'b10; src_e=0 with writereg_m=0 -> 2'b00.
REQ-035 SHALL cover: memtoreg_e=1 writereg_e=8, src_d slot1=8 -> stall_f=stall_d=flush_e=1; writereg_e=9 -> all 0.
REQ-036 SHALL cover: lat_issue_e dest 12; next cycles src_d=12 -> stall; lat_done dest 12 -> stall that cycle, stall=0 the cycle after, sb_busy[12]=0.
REQ-037 SHALL cover: sb_busy[3]=1, same cycle lat_issue_e dest 3 and lat_done dest 3 -> sb_busy[3]=1 next cycle; lat_issue_e dest 0 -> sb_busy[0]=0.
REQ-038 SHALL cover: sb_busy=32'h0000_1010 then reset=1 with lat_issue_e dest 7 -> sb_busy=0 next cycle; stall_cnt=0 when HAZARD_STALL_CNT_EN defined.
REQ-039 SHALL cover: branch_d=1, src_d slot0=4, regwrite_e=1 writereg_e=4 -> stall=1; then writereg_m=4 regwrite_m=1 memtoreg_m=0 -> stall=0, forward_d[0]=1.
